// File: rtl/lsu_rv32i_pkg.sv
// Shared encodings for the RV32I load/store unit: control-unit load/store types,
// FSM state encoding and the alignment rule used when an access is accepted.
package rv32i_lsu_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Unlisted load/store encodings behave as full-word accesses.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] loadtype,
                                           input logic [1:0] storetype,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            case (storetype)
                ST_SB:   mis = 1'b0;
                ST_SH:   mis = addr_lo[0];
                default: mis = |addr_lo;
            endcase
        end else begin
            case (loadtype)
                LT_LB, LT_LBU: mis = 1'b0;
                LT_LH, LT_LHU: mis = addr_lo[0];
                default:       mis = |addr_lo;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_rv32i_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_rv32i_load_ext.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it according to the load type.
module lsu_load_ext
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  loadtype,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (loadtype)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LBU:  result = {24'h0, byte_sel};
            LT_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: registered req/ack memory access with lane placement,
// load extension and core stall. Define LSU_TIMEOUT_EN to abort unacknowledged requests.
module lsu_rv32i
    import rv32i_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        lsu_load,
    input  logic        cu_store,
    input  logic [2:0]  cu_loadtype,
    input  logic [1:0]  cu_storetype,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_valid,
    output logic        lsu_misalign,
    lsu_mem_if.master   mem
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("lsu_rv32i: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t  state, state_next;
    logic        access, misaligned, timeout_hit;
    logic        stall_c, req_c, valid_c, misalign_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_ext;

    logic        err_q, is_load_q, we_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  loadtype_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;

    assign access     = lsu_load | cu_store;
    assign misaligned = is_misaligned(cu_store, cu_loadtype, cu_storetype, lsu_addr[1:0]);

    lsu_load_ext u_load_ext (
        .rdata    (mem.mem_rdata),
        .addr_lo  (addr_lo_q),
        .loadtype (loadtype_q),
        .result   (load_ext)
    );

    // Store data is replicated across lanes; the byte enables pick the real target.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        if (cu_store) begin
            case (cu_storetype)
                ST_SB: begin
                    be_c    = 4'b0001 << lsu_addr[1:0];
                    wdata_c = {4{lsu_wdata[7:0]}};
                end
                ST_SH: begin
                    be_c    = 4'b0011 << {lsu_addr[1], 1'b0};
                    wdata_c = {2{lsu_wdata[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = lsu_wdata;
                end
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == REQ && !mem.mem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = !mem.mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        req_c      = 1'b0;
        valid_c    = 1'b0;
        misalign_c = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall_c    = 1'b1;
                    state_next = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                if (mem.mem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_c    = !err_q;
                misalign_c = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access attributes are frozen on acceptance so the bus stays stable through REQ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q      <= 1'b0;
            is_load_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_lo_q  <= 2'b00;
            loadtype_q <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        err_q <= misaligned;
                        if (misaligned) begin
                            rdata_q <= 32'h0;
                        end else begin
                            is_load_q  <= !cu_store;
                            we_q       <= cu_store;
                            addr_lo_q  <= lsu_addr[1:0];
                            loadtype_q <= cu_loadtype;
                            addr_q     <= {lsu_addr[31:2], 2'b00};
                            wdata_q    <= wdata_c;
                            be_q       <= be_c;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        if (is_load_q) begin
                            rdata_q <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_stall     = stall_c & reset_n;
    assign lsu_valid     = valid_c;
    assign lsu_misalign  = misalign_c;
    assign lsu_rdata     = rdata_q;
    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule
